mmio_fifo_bank: RTL
===================

Name: mmio_fifo_bank

Overview:
- Parametrised MMIO-mapped FIFO; next generation of the single-register FIFO hanging off the AFU's MMIO write path.
- The host pushes words with MMIO writes and pops them with MMIO reads. Status, control and peek registers are mapped alongside the data port.
- Sits between the AFU's decoded CCI-P c0 MMIO request fields and the c2 read-response mux.
- Asserts a hit flag on reads it owns, so the AFU returns 0 for unmapped addresses.

Parameters:
- DATA_W, 64: stored word width, 1..64. Read data is zero-extended to 64 bits.
- DEPTH, 8: FIFO entries; power of two, at least 2.
- BASE_ADDR, 16'h0020: MMIO address of register 0, in CCI-P 32-bit word units; must be a multiple of 8.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- mmio_wr_valid  in  1  MMIO write request this cycle (rx.c0.mmioWrValid)
- mmio_rd_valid  in  1  MMIO read request this cycle (rx.c0.mmioRdValid)
- mmio_addr  in  16  request address (mmio_hdr.address)
- mmio_tid  in  9  request TID (mmio_hdr.tid)
- mmio_wr_data  in  64  write data (rx.c0.data[63:0])
- rd_resp_valid  out  1  read response valid, one-cycle pulse
- rd_resp_hit  out  1  response address decoded by this block
- rd_resp_tid  out  9  TID echoed from the request
- rd_resp_data  out  64  response data
- fifo_count  out  $clog2(DEPTH+1)  current occupancy, for debug/LEDs

Behaviour:
- Register map, offsets from BASE_ADDR, 64-bit registers:
  - +0 DATA: write pushes mmio_wr_data[DATA_W-1:0]; read pops and returns the head.
  - +2 STATUS (RO): [15:0] count; [16] empty; [17] full; [18] overflow (sticky); [19] underflow (sticky); [47:32] DEPTH; rest 0.
  - +4 CONTROL (WO, reads return 0 with hit=1): bit0 = flush FIFO; bit1 = clear sticky flags; other bits ignored.
  - +6 PEEK (RO): head without popping; 0 if empty.
- Addresses outside BASE..BASE+7, and odd offsets: writes ignored; reads give valid=1, hit=0, data=0.
- Reset: all outputs 0, pointers 0, count 0, flags 0. Storage contents need not be cleared.
- Read latency:
  - Exactly one cycle: request at cycle N gives rd_resp_valid=1 at N+1 with tid and data; valid=0 otherwise.
  - Back-to-back reads every cycle are supported.
  - Pop data is the head at the request edge.
- Push:
  - If not full, write at wr_ptr; wr_ptr++ mod DEPTH; count++.
  - If full, drop the word, set overflow, count unchanged.
- Pop:
  - If not empty, return mem[rd_ptr]; rd_ptr++ mod DEPTH; count--.
  - If empty, return 0, set underflow, pointers unchanged.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count runs 0..DEPTH; full = (count==DEPTH), empty = (count==0).
- Simultaneous write and read in the same cycle (both valids high) are both processed:
  - Both at DATA, 0<count<DEPTH: pop returns the old head, push appends, count unchanged.
  - Both at DATA, empty: pop underflows (data 0, underflow set); push succeeds; count becomes 1.
  - Both at DATA, full: pop frees a slot, push accepted, no overflow, count stays DEPTH.
  - Read STATUS + write DATA: STATUS reflects the pre-write state.
- Flush (CONTROL bit0):
  - Next cycle pointers and count are 0; sticky flags are unchanged unless bit1 is also set.
  - A same-cycle DATA read still returns the pre-flush head; the flush wins over the pop side effects.
- Reset mid-operation: a read requested in the reset cycle gets no response. State returns to reset values next cycle.

Test Plan:
- Reset, then read BASE+2 -> valid at +1 cycle, data=64'h0000_0008_0001_0000 (DEPTH=8, empty); fifo_count=0.
- Push 1..8 to BASE+0, push 9 -> STATUS count=8, full=1, overflow=1. Then 8 pops return 1..8 in order; 9th pop returns 0 with underflow=1.
- Push A,B, read BASE+6 twice -> A both times, count stays 2. Then 10 push/pop pairs spanning wrap-around -> FIFO order preserved, fifo_count never exceeds 2.
- Empty FIFO, same cycle write DATA=0x55 and read DATA -> read returns 0, underflow=1, count=1. Next pop returns 0x55.
- Full FIFO, same cycle push 0xAA and pop -> returns oldest, overflow stays 0, count=8. The last pop of the drain returns 0xAA.
- Write CONTROL=3 with 5 entries and flags set -> STATUS=empty, count 0, flags 0. Read 16'h0040 with tid 9'h1A3 -> valid=1, hit=0, tid=9'h1A3, data=0.

Source files
------------

// File: rtl/mmio_fifo_bank.sv
// MMIO-mapped FIFO: DATA push/pop port plus STATUS, CONTROL and PEEK registers,
// answering CCI-P style MMIO reads with a one-cycle registered response.
module mmio_fifo_bank #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned DEPTH     = 8,
  parameter logic [15:0] BASE_ADDR = 16'h0020,
  localparam int unsigned PW       = $clog2(DEPTH),
  localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mmio_wr_valid,
  input  logic          mmio_rd_valid,
  input  logic [15:0]   mmio_addr,
  input  logic [8:0]    mmio_tid,
  input  logic [63:0]   mmio_wr_data,
  output logic          rd_resp_valid,
  output logic          rd_resp_hit,
  output logic [8:0]    rd_resp_tid,
  output logic [63:0]   rd_resp_data,
  output logic [CW-1:0] fifo_count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              resp_valid_q, resp_hit_q;
  logic [8:0]        resp_tid_q;
  logic [63:0]       resp_data_q, resp_data_d;

  logic        addr_hit, sel_data, sel_ctrl;
  logic [1:0]  reg_off;
  logic        empty, full, pop_req, push_req, pop_ok, push_ok, flush, clr_flags;
  logic [63:0] head, status;

  // Registers are 64-bit, so only even 32-bit-word offsets inside the 8-word window decode.
  assign addr_hit = (mmio_addr[15:3] == BASE_ADDR[15:3]) && !mmio_addr[0];
  assign reg_off  = mmio_addr[2:1];
  assign sel_data = addr_hit && (reg_off == 2'd0);
  assign sel_ctrl = addr_hit && (reg_off == 2'd2);

  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CW'(DEPTH));
    push_req  = mmio_wr_valid && sel_data;
    pop_req   = mmio_rd_valid && sel_data;
    pop_ok    = pop_req && !empty;
    // A same-cycle pop frees the slot, so a push into a full FIFO is still accepted.
    push_ok   = push_req && (!full || pop_ok);
    flush     = mmio_wr_valid && sel_ctrl && mmio_wr_data[0];
    clr_flags = mmio_wr_valid && sel_ctrl && mmio_wr_data[1];

    head = '0;
    if (!empty) head[DATA_W-1:0] = mem_q[rd_ptr_q];
    status = {16'h0, 16'(DEPTH), 12'h0, udf_q, ovf_q, full, empty, 16'(count_q)};

    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    ovf_d    = (ovf_q && !clr_flags) || (push_req && !push_ok);
    udf_d    = (udf_q && !clr_flags) || (pop_req && empty);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end

    resp_data_d = '0;
    if (mmio_rd_valid && addr_hit) begin
      case (reg_off)
        2'd0:    resp_data_d = head;
        2'd1:    resp_data_d = status;
        2'd2:    resp_data_d = '0;
        default: resp_data_d = head;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_tid_q   <= '0;
      resp_data_q  <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
      resp_valid_q <= mmio_rd_valid;
      resp_hit_q   <= mmio_rd_valid && addr_hit;
      resp_tid_q   <= mmio_rd_valid ? mmio_tid : 9'h0;
      resp_data_q  <= resp_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= mmio_wr_data[DATA_W-1:0];
  end

  assign rd_resp_valid = resp_valid_q;
  assign rd_resp_hit   = resp_hit_q;
  assign rd_resp_tid   = resp_tid_q;
  assign rd_resp_data  = resp_data_q;
  assign fifo_count    = count_q;

endmodule
